// File: rtl/sequenciador_de_pc.sv
// Next-PC sequencer: picks the value the program counter register loads every posedge,
// covering boot, halt/resume, stall, jump/branch and a single-level interrupt with return.
module sequenciador_de_pc #(
   parameter logic [25:0] VETOR_INT = 26'h0000040,
   parameter logic [25:0] END_BOOT  = 26'h0000000
) (
   input  logic        clock,
   input  logic        pc_reset,
   input  logic [25:0] pc_atual,
   output logic [25:0] endereco,
   input  logic        stall,
   input  logic        jump,
   input  logic [25:0] jump_alvo,
   input  logic        desvio,
   input  logic [25:0] desvio_alvo,
   input  logic        halt,
   input  logic        resume,
   input  logic        irq,
   input  logic        eret,
   output logic        irq_ack,
   output logic [25:0] epc,
   output logic        em_isr,
   output logic        parado
);

   typedef enum logic [1:0] {StBoot, StRun, StHalt} estado_t;

   estado_t     estado_q, estado_d;
   logic [25:0] epc_q, epc_d;
   logic        em_isr_q, em_isr_d;
   logic        parado_q, parado_d;
   logic        irq_ack_q, irq_ack_d;

   logic [25:0] pc_inc;
   logic [25:0] alvo_seq;
   logic        eret_ok;
   logic        irq_ok;

   always_comb begin
      pc_inc  = pc_atual + 26'd1;
      eret_ok = eret & em_isr_q;
      irq_ok  = irq & ~em_isr_q;

      // Target the sequence would take without an interrupt; also the saved return address.
      if (eret_ok)     alvo_seq = epc_q;
      else if (jump)   alvo_seq = jump_alvo;
      else if (desvio) alvo_seq = desvio_alvo;
      else             alvo_seq = pc_inc;

      estado_d  = estado_q;
      epc_d     = epc_q;
      em_isr_d  = em_isr_q;
      parado_d  = parado_q;
      irq_ack_d = 1'b0;
      endereco  = pc_atual;

      case (estado_q)
         StRun: begin
            if (halt) begin
               estado_d = StHalt;
               parado_d = 1'b1;
            end else if (irq_ok && !stall) begin
               endereco  = VETOR_INT;
               epc_d     = alvo_seq;
               em_isr_d  = 1'b1;
               irq_ack_d = 1'b1;
            end else if (!stall) begin
               endereco = alvo_seq;
               if (eret_ok) em_isr_d = 1'b0;
            end
         end
         StHalt: begin
            if (irq_ok) begin
               endereco  = VETOR_INT;
               epc_d     = pc_inc;
               em_isr_d  = 1'b1;
               irq_ack_d = 1'b1;
               parado_d  = 1'b0;
               estado_d  = StRun;
            end else if (resume) begin
               parado_d = 1'b0;
               estado_d = StRun;
            end
         end
         default: begin
            endereco = END_BOOT;
            estado_d = StRun;
         end
      endcase

      if (pc_reset) endereco = END_BOOT;
   end

   always_ff @(posedge clock or posedge pc_reset) begin
      if (pc_reset) begin
         estado_q  <= StBoot;
         epc_q     <= 26'd0;
         em_isr_q  <= 1'b0;
         parado_q  <= 1'b0;
         irq_ack_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         epc_q     <= epc_d;
         em_isr_q  <= em_isr_d;
         parado_q  <= parado_d;
         irq_ack_q <= irq_ack_d;
      end
   end

   assign epc     = epc_q;
   assign em_isr  = em_isr_q;
   assign parado  = parado_q;
   assign irq_ack = irq_ack_q;

endmodule

// File: tb/tb_sequenciador_de_pc.sv
// Bench for sequenciador_de_pc: a PC register closes the loop on endereco; table vectors
// give per-cycle requests and the expected state after the following posedge.
module tb_sequenciador_de_pc;

   localparam int unsigned S = 1, J = 2, D = 4, H = 8, R = 16, I = 32, E = 64;

   typedef struct {
      int unsigned req;
      logic [25:0] ja;
      logic [25:0] da;
      logic [25:0] exp_pc;
      logic        exp_ack;
      logic [25:0] exp_epc;
      logic        exp_isr;
      logic        exp_par;
   } vec_t;

   logic        clock = 1'b0;
   logic        pc_reset;
   logic [25:0] pc_atual;
   logic [25:0] endereco;
   logic        stall, jump, desvio, halt, resume, irq, eret;
   logic [25:0] jump_alvo, desvio_alvo;
   logic        irq_ack, em_isr, parado;
   logic [25:0] epc;

   int n_chk = 0;
   int n_fail = 0;
   vec_t tbl[$];
   vec_t sb[$];

   sequenciador_de_pc dut (
      .clock       (clock),
      .pc_reset    (pc_reset),
      .pc_atual    (pc_atual),
      .endereco    (endereco),
      .stall       (stall),
      .jump        (jump),
      .jump_alvo   (jump_alvo),
      .desvio      (desvio),
      .desvio_alvo (desvio_alvo),
      .halt        (halt),
      .resume      (resume),
      .irq         (irq),
      .eret        (eret),
      .irq_ack     (irq_ack),
      .epc         (epc),
      .em_isr      (em_isr),
      .parado      (parado)
   );

   always #5 clock = ~clock;

   // Program counter register with no enable, as the sequencer expects.
   always @(posedge clock or posedge pc_reset) begin
      if (pc_reset) pc_atual <= 26'd0;
      else          pc_atual <= endereco;
   end

   function automatic vec_t v(int unsigned req, logic [25:0] ja, logic [25:0] da,
                              logic [25:0] pc, logic ack, logic [25:0] e, logic isr,
                              logic par);
      vec_t r;
      r.req = req; r.ja = ja; r.da = da;
      r.exp_pc = pc; r.exp_ack = ack; r.exp_epc = e; r.exp_isr = isr; r.exp_par = par;
      return r;
   endfunction

   task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t x);
      stall       = (x.req & S) != 0;
      jump        = (x.req & J) != 0;
      desvio      = (x.req & D) != 0;
      halt        = (x.req & H) != 0;
      resume      = (x.req & R) != 0;
      irq         = (x.req & I) != 0;
      eret        = (x.req & E) != 0;
      jump_alvo   = x.ja;
      desvio_alvo = x.da;
   endtask

   // Called at a negedge: apply requests, let one posedge pass, compare, return at negedge.
   task automatic step(input vec_t x, input int idx);
      vec_t e;
      drive(x);
      sb.push_back(x);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d pc_atual", idx), pc_atual, e.exp_pc);
      chk($sformatf("v%0d irq_ack", idx), {25'd0, irq_ack}, {25'd0, e.exp_ack});
      chk($sformatf("v%0d epc", idx), epc, e.exp_epc);
      chk($sformatf("v%0d em_isr", idx), {25'd0, em_isr}, {25'd0, e.exp_isr});
      chk($sformatf("v%0d parado", idx), {25'd0, parado}, {25'd0, e.exp_par});
      @(negedge clock);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " irq_ack"}, {25'd0, irq_ack}, 26'd0);
      chk({tag, " epc"}, epc, 26'd0);
      chk({tag, " em_isr"}, {25'd0, em_isr}, 26'd0);
      chk({tag, " parado"}, {25'd0, parado}, 26'd0);
      chk({tag, " endereco"}, endereco, 26'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // req, jump_alvo, desvio_alvo -> pc, ack, epc, em_isr, parado after the posedge
      tbl.push_back(v(J|I|H, 26'h100, 0, 26'h0, 0, 26'h0, 0, 0)); // BOOT ignores requests
      tbl.push_back(v(0, 0, 0, 26'h1, 0, 26'h0, 0, 0));
      tbl.push_back(v(0, 0, 0, 26'h2, 0, 26'h0, 0, 0));
      tbl.push_back(v(0, 0, 0, 26'h3, 0, 26'h0, 0, 0));
      tbl.push_back(v(J, 26'h10, 0, 26'h10, 0, 26'h0, 0, 0));
      tbl.push_back(v(J|D, 26'h200, 26'h300, 26'h200, 0, 26'h0, 0, 0));
      tbl.push_back(v(J, 26'h20, 0, 26'h20, 0, 26'h0, 0, 0));
      tbl.push_back(v(I|D, 0, 26'h80, 26'h40, 1, 26'h80, 1, 0));
      tbl.push_back(v(0, 0, 0, 26'h41, 0, 26'h80, 1, 0));
      for (int k = 0; k < 5; k++) tbl.push_back(v(I, 0, 0, 26'h42 + k, 0, 26'h80, 1, 0));
      tbl.push_back(v(E|I, 0, 0, 26'h80, 0, 26'h80, 0, 0));
      tbl.push_back(v(I, 0, 0, 26'h40, 1, 26'h81, 1, 0));
      tbl.push_back(v(E, 0, 0, 26'h81, 0, 26'h81, 0, 0));
      tbl.push_back(v(E|D, 0, 26'h30, 26'h30, 0, 26'h81, 0, 0)); // eret outside ISR ignored
      tbl.push_back(v(H, 0, 0, 26'h30, 0, 26'h81, 0, 1));
      tbl.push_back(v(0, 0, 0, 26'h30, 0, 26'h81, 0, 1));
      tbl.push_back(v(J, 26'h500, 0, 26'h30, 0, 26'h81, 0, 1));
      tbl.push_back(v(I, 0, 0, 26'h40, 1, 26'h31, 1, 0));
      tbl.push_back(v(0, 0, 0, 26'h41, 0, 26'h31, 1, 0));
      tbl.push_back(v(E, 0, 0, 26'h31, 0, 26'h31, 0, 0));
      tbl.push_back(v(S|I|J, 26'h99, 0, 26'h31, 0, 26'h31, 0, 0));
      tbl.push_back(v(I|J, 26'h99, 0, 26'h40, 1, 26'h99, 1, 0));
      tbl.push_back(v(S|E, 0, 0, 26'h40, 0, 26'h99, 1, 0));
      tbl.push_back(v(E|J, 26'h77, 0, 26'h99, 0, 26'h99, 0, 0));
      tbl.push_back(v(H|I, 0, 0, 26'h99, 0, 26'h99, 0, 1));
      tbl.push_back(v(R, 0, 0, 26'h99, 0, 26'h99, 0, 0));
      tbl.push_back(v(0, 0, 0, 26'h9A, 0, 26'h99, 0, 0));
      tbl.push_back(v(J, 26'h3FFFFFF, 0, 26'h3FFFFFF, 0, 26'h99, 0, 0));
      tbl.push_back(v(0, 0, 0, 26'h0, 0, 26'h99, 0, 0));
      tbl.push_back(v(J, 26'h3FFFFFF, 0, 26'h3FFFFFF, 0, 26'h99, 0, 0));
      tbl.push_back(v(S, 0, 0, 26'h3FFFFFF, 0, 26'h99, 0, 0));
      tbl.push_back(v(S|J, 26'h5, 0, 26'h3FFFFFF, 0, 26'h99, 0, 0));
      tbl.push_back(v(S, 0, 0, 26'h3FFFFFF, 0, 26'h99, 0, 0));
      tbl.push_back(v(0, 0, 0, 26'h0, 0, 26'h99, 0, 0));
      tbl.push_back(v(H, 0, 0, 26'h0, 0, 26'h99, 0, 1));
      tbl.push_back(v(R|I, 0, 0, 26'h40, 1, 26'h1, 1, 0));
      tbl.push_back(v(H, 0, 0, 26'h40, 0, 26'h1, 1, 1));
      tbl.push_back(v(I, 0, 0, 26'h40, 0, 26'h1, 1, 1));
      tbl.push_back(v(R, 0, 0, 26'h40, 0, 26'h1, 1, 0));
      tbl.push_back(v(0, 0, 0, 26'h41, 0, 26'h1, 1, 0));
      tbl.push_back(v(E, 0, 0, 26'h1, 0, 26'h1, 0, 0));
      tbl.push_back(v(I, 0, 0, 26'h40, 1, 26'h2, 1, 0));

      pc_reset = 1'b1;
      drive(v(J|I, 26'h123, 26'h0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk_reset_state("reset");
      chk("reset pc_atual", pc_atual, 26'd0);
      pc_reset = 1'b0;

      for (int n = 0; n < tbl.size(); n++) step(tbl[n], n);

      // Reset in the cycle right after interrupt entry discards the saved context.
      drive(v(0, 0, 0, 0, 0, 0, 0, 0));
      pc_reset = 1'b1;
      #1;
      chk_reset_state("reset mid-isr");
      @(negedge clock);
      pc_reset = 1'b0;
      step(v(0, 0, 0, 26'h0, 0, 26'h0, 0, 0), 100);
      step(v(H, 0, 0, 26'h0, 0, 26'h0, 0, 1), 101);

      // Reset while halted.
      pc_reset = 1'b1;
      #1;
      chk_reset_state("reset mid-halt");
      @(negedge clock);
      pc_reset = 1'b0;
      step(v(0, 0, 0, 26'h0, 0, 26'h0, 0, 0), 102);
      step(v(0, 0, 0, 26'h1, 0, 26'h0, 0, 0), 103);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sequenciador_de_pc.md
SEQUENCIADOR_DE_PC -- requirements
Module: sequenciador_de_pc

Interface
REQ-001 Parameter VETOR_INT, default 26'h0000040, 26-bit interrupt service entry address.
REQ-002 Parameter END_BOOT, default 26'h0000000, first fetch address after reset.
REQ-003 clock  input  1  clock; all state updates on posedge.
REQ-004 pc_reset  input  1  reset, asynchronous, active-high.
REQ-005 pc_atual  input  26  current value of the program counter register.
REQ-006 endereco  output  26  next PC value, combinational, captured by the program counter register every posedge.
REQ-007 stall  input  1  pipeline hold request.
REQ-008 jump / jump_alvo  input  1 / 26  unconditional jump request and target.
REQ-009 desvio / desvio_alvo  input  1 / 26  taken-branch request and target.
REQ-010 halt / resume  input  1 / 1  stop request and wake request.
REQ-011 irq  input  1  level interrupt request.
REQ-012 eret  input  1  return-from-interrupt request.
REQ-013 irq_ack  output  1  one-cycle registered pulse when an interrupt is taken.
REQ-014 epc  output  26  saved return address, registered.
REQ-015 em_isr / parado  output  1 / 1  registered status: servicing interrupt / halted.

Function
REQ-016 The block SHALL implement FSM states BOOT, RUN, HALT; the program counter register has no enable, so every hold SHALL drive endereco = pc_atual.
REQ-017 BOOT: endereco = END_BOOT; unconditional transition to RUN on the next posedge; all requests ignored.
REQ-018 RUN: endereco SHALL be selected by fixed priority: halt > irq taken > stall > eret > jump > desvio > pc_atual+1.
REQ-019 Interrupt taken when irq=1, em_isr=0, stall=0: endereco = VETOR_INT; epc <= the address the lower-priority selection (eret/jump/desvio/pc_atual+1) would have produced; em_isr <= 1; irq_ack <= 1 for exactly one cycle.
REQ-020 irq while em_isr=1 or stall=1 SHALL be held off (no ack, no vector); taken on the first eligible cycle while still asserted.
REQ-021 halt in RUN: endereco = pc_atual; next state HALT; parado <= 1.
REQ-022 stall: endereco = pc_atual; state, epc, em_isr unchanged.
REQ-023 eret with em_isr=1: endereco = epc; em_isr <= 0. eret with em_isr=0 SHALL be ignored (falls through to jump/desvio/+1).
REQ-024 jump and desvio both asserted: jump wins.
REQ-025 pc_atual+1 SHALL be 26-bit modulo: 26'h3FFFFFF -> 26'h0000000, no carry output.
REQ-026 HALT: endereco = pc_atual; resume=1 -> RUN next posedge, parado <= 0; endereco still pc_atual during the resume cycle.
REQ-027 HALT with irq=1, em_isr=0 (priority over resume): endereco = VETOR_INT; epc <= pc_atual+1; em_isr <= 1; irq_ack pulse; parado <= 0; next state RUN.
REQ-028 irq_ack SHALL be 0 in every cycle where an interrupt is not taken.
REQ-029 Redirect latency: request sampled in cycle N -> pc_atual equals target after posedge ending cycle N (one cycle).

Reset
REQ-030 pc_reset=1 SHALL immediately force state BOOT, epc=0, em_isr=0, parado=0, irq_ack=0, independent of clock.
REQ-031 While pc_reset=1, endereco = END_BOOT; reset asserted mid-interrupt entry or mid-halt SHALL discard all saved context.
REQ-032 After release, exactly one BOOT cycle precedes RUN; first sequential increment appears on the second posedge.

Verification
REQ-033 Reset release, no requests -> pc_atual sequence 0,0,1,2,3; irq_ack=0 throughout.
REQ-034 pc_atual=26'h0000010, jump=1 jump_alvo=26'h0000200 and desvio=1 desvio_alvo=26'h0000300 -> next pc_atual=26'h0000200.
REQ-035 pc_atual=26'h0000020, irq=1, desvio=1 to 26'h0000080 -> pc_atual=26'h0000040, epc=26'h0000080, irq_ack single pulse, em_isr=1; later eret -> pc_atual=26'h0000080, em_isr=0.
REQ-036 em_isr=1, irq held high 5 cycles -> no ack, no vector; after eret, irq still high -> taken on next RUN cycle.
REQ-037 pc_atual=26'h0000030, halt=1 -> PC frozen at 26'h0000030, parado=1; irq=1 -> pc_atual=26'h0000040, epc=26'h0000031.
REQ-038 pc_atual=26'h3FFFFFF, no requests -> next pc_atual=26'h0000000; stall=1 for 3 cycles -> PC unchanged 3 cycles.
